// File: rtl/onehot_decoder_seq_pkg.sv
// Shared definitions for the registered one-hot decoder: FSM encoding and
// a one-hot helper sized for the widest supported decoder.
package onehot_decoder_seq_pkg;

  // Widest decoder supported by the helper (SEL_W up to 8).
  localparam int ONEHOT_SEL_MAX = 8;
  localparam int ONEHOT_MAX_W   = 2 ** ONEHOT_SEL_MAX;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Returns 1 << idx at the maximum width; callers size-cast to OUT_W.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_SEL_MAX-1:0] idx);
    logic [ONEHOT_MAX_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a SWEEP mode that walks a
// single hot bit across outputs 0..SWEEP_LAST for register-file init/clear.
module onehot_decoder_seq
  import onehot_decoder_seq_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int SWEEP_LAST = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sweep_start,
  output logic [(2**SEL_W)-1:0] out_dec,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(SWEEP_LAST);

  // Static parameter checks, evaluated at elaboration.
  if (SEL_W < 1 || SEL_W > ONEHOT_SEL_MAX) begin : g_bad_sel_w
    $error("onehot_decoder_seq: SEL_W must be in 1..%0d", ONEHOT_SEL_MAX);
  end
  if (SWEEP_LAST < 0 || SWEEP_LAST > OUT_W - 1) begin : g_bad_sweep_last
    $error("onehot_decoder_seq: SWEEP_LAST must be in 0..%0d", OUT_W - 1);
  end

  state_e           state;
  logic [SEL_W-1:0] idx;

  // Single FSM: state, sweep index and every output are registered here.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values; reset is asynchronous so outputs
  // clear immediately, even mid-sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_dec   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (sweep_start) begin
            // Sweep wins over a same-cycle decode request.
            state     <= ST_SWEEP;
            idx       <= '0;
            out_dec   <= OUT_W'(onehot('0));
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end else if (en) begin
            out_dec   <= OUT_W'(onehot(ONEHOT_SEL_MAX'(sel)));
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            out_dec   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        ST_SWEEP: begin
          // en/sel/sweep_start are ignored; the compare ends the sweep
          // before idx could wrap.
          if (idx == LAST_IDX) begin
            state     <= ST_DONE;
            out_dec   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            idx       <= idx + 1'b1;
            out_dec   <= out_dec << 1;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_DONE: begin
          // One-cycle completion pulse; inputs are ignored here.
          state     <= ST_IDLE;
          idx       <= '0;
          out_dec   <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          idx       <= '0;
          out_dec   <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed + randomised bench for onehot_decoder_seq: default (4,15),
// a (3,5) instance and a (2,0) instance share clock and reset.
module tb_onehot_decoder_seq;

  logic clk;
  logic reset;

  // Instance A: SEL_W=4, SWEEP_LAST=15
  logic        a_en, a_start;
  logic [3:0]  a_sel;
  logic [15:0] a_out;
  logic        a_valid, a_busy, a_done;

  // Instance B: SEL_W=3, SWEEP_LAST=5
  logic        b_en, b_start;
  logic [2:0]  b_sel;
  logic [7:0]  b_out;
  logic        b_valid, b_busy, b_done;

  // Instance C: SEL_W=2, SWEEP_LAST=0
  logic        c_en, c_start;
  logic [1:0]  c_sel;
  logic [3:0]  c_out;
  logic        c_valid, c_busy, c_done;

  int checks;
  int errors;

  onehot_decoder_seq #(.SEL_W(4), .SWEEP_LAST(15)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .sel(a_sel), .sweep_start(a_start),
    .out_dec(a_out), .out_valid(a_valid), .busy(a_busy), .done(a_done)
  );

  onehot_decoder_seq #(.SEL_W(3), .SWEEP_LAST(5)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .sel(b_sel), .sweep_start(b_start),
    .out_dec(b_out), .out_valid(b_valid), .busy(b_busy), .done(b_done)
  );

  onehot_decoder_seq #(.SEL_W(2), .SWEEP_LAST(0)) dut_c (
    .clk(clk), .reset(reset), .en(c_en), .sel(c_sel), .sweep_start(c_start),
    .out_dec(c_out), .out_valid(c_valid), .busy(c_busy), .done(c_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_en = 0; a_start = 0; a_sel = '0;
    b_en = 0; b_start = 0; b_sel = '0;
    c_en = 0; c_start = 0; c_sel = '0;
    step();
    step();
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_a: got out=%h v/b/d=%b%b%b expected out=0000 v/b/d=000",
               a_out, a_valid, a_busy, a_done);
    end
    checks++;
    if ({b_out, b_valid, b_busy, b_done, c_out, c_valid, c_busy, c_done} !== 18'h0) begin
      errors++;
      $display("FAIL reset_bc: got b=%h %b%b%b c=%h %b%b%b expected all zero",
               b_out, b_valid, b_busy, b_done, c_out, c_valid, c_busy, c_done);
    end
    #3 reset = 1'b0;
    step();
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_release_idle: got out=%h v/b/d=%b%b%b expected out=0000 v/b/d=000",
               a_out, a_valid, a_busy, a_done);
    end
  endtask

  task automatic test_decode_all();
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      a_en = 1'b1; a_sel = 4'(i);
      step();
      exp = 16'h0001 << i;
      checks++;
      if ({a_out, a_valid, a_busy, a_done} !== {exp, 3'b100}) begin
        errors++;
        $display("FAIL decode_sel%0d: got out=%h v/b/d=%b%b%b expected out=%h v/b/d=100",
                 i, a_out, a_valid, a_busy, a_done, exp);
      end
    end
    a_en = 1'b0;
    step();
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL decode_en_low: got out=%h v=%b expected out=0000 v=0", a_out, a_valid);
    end
  endtask

  task automatic test_sweep_full();
    logic [15:0] exp;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = 16'h0001 << i;
      checks++;
      if ({a_out, a_valid, a_busy, a_done} !== {exp, 3'b110}) begin
        errors++;
        $display("FAIL sweep_bit%0d: got out=%h v/b/d=%b%b%b expected out=%h v/b/d=110",
                 i, a_out, a_valid, a_busy, a_done, exp);
      end
      step();
    end
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b001}) begin
      errors++;
      $display("FAIL sweep_done: got out=%h v/b/d=%b%b%b expected out=0000 v/b/d=001",
               a_out, a_valid, a_busy, a_done);
    end
    step();
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL sweep_idle_after: got out=%h v/b/d=%b%b%b expected out=0000 v/b/d=000",
               a_out, a_valid, a_busy, a_done);
    end
  endtask

  task automatic test_priority();
    logic [15:0] exp;
    // sweep_start and en on the same edge: sweep wins.
    a_start = 1'b1; a_en = 1'b1; a_sel = 4'd5;
    step();
    a_start = 1'b0; a_sel = 4'd3;  // en stays high mid-sweep and must be ignored
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0001, 3'b110}) begin
      errors++;
      $display("FAIL prio_sweep_wins: got out=%h busy=%b expected out=0001 busy=1", a_out, a_busy);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      exp = 16'h0001 << i;
      checks++;
      if ({a_out, a_busy} !== {exp, 1'b1}) begin
        errors++;
        $display("FAIL prio_ignore_en_bit%0d: got out=%h busy=%b expected out=%h busy=1",
                 i, a_out, a_busy, exp);
      end
    end
    step();
    checks++;
    if ({a_out, a_busy, a_done} !== {16'h0000, 2'b01}) begin
      errors++;
      $display("FAIL prio_done: got out=%h b/d=%b%b expected out=0000 b/d=01", a_out, a_busy, a_done);
    end
    // Inputs during DONE are ignored.
    a_start = 1'b1; a_en = 1'b1; a_sel = 4'd9;
    step();
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL done_ignores_inputs: got out=%h v/b/d=%b%b%b expected out=0000 v/b/d=000",
               a_out, a_valid, a_busy, a_done);
    end
    // First IDLE cycle accepts a new sweep.
    step();
    a_start = 1'b0; a_en = 1'b0;
    checks++;
    if ({a_out, a_busy} !== {16'h0001, 1'b1}) begin
      errors++;
      $display("FAIL restart_first_idle: got out=%h busy=%b expected out=0001 busy=1", a_out, a_busy);
    end
    for (int i = 0; i < 17; i++) step();
    checks++;
    if ({a_out, a_busy, a_done} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL restart_complete: got out=%h b/d=%b%b expected out=0000 b/d=00", a_out, a_busy, a_done);
    end
  endtask

  task automatic test_async_reset();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if ({a_out, a_busy} !== {16'h0080, 1'b1}) begin
      errors++;
      $display("FAIL areset_reach_bit7: got out=%h busy=%b expected out=0080 busy=1", a_out, a_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_out, a_valid, a_busy, a_done} !== {16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL areset_immediate: got out=%h v/b/d=%b%b%b expected out=0000 v/b/d=000",
               a_out, a_valid, a_busy, a_done);
    end
    #2 reset = 1'b0;
    a_en = 1'b1; a_sel = 4'd2;
    step();
    a_en = 1'b0;
    checks++;
    if ({a_out, a_valid, a_busy} !== {16'h0004, 2'b10}) begin
      errors++;
      $display("FAIL areset_then_decode: got out=%h v/b=%b%b expected out=0004 v/b=10",
               a_out, a_valid, a_busy);
    end
  endtask

  task automatic test_param_sel3_last5();
    logic [7:0] exp;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = 8'h01 << i;
      checks++;
      if ({b_out, b_valid, b_busy, b_done} !== {exp, 3'b110}) begin
        errors++;
        $display("FAIL b_sweep_bit%0d: got out=%h v/b/d=%b%b%b expected out=%h v/b/d=110",
                 i, b_out, b_valid, b_busy, b_done, exp);
      end
      step();
    end
    checks++;
    if ({b_out, b_valid, b_busy, b_done} !== {8'h00, 3'b001}) begin
      errors++;
      $display("FAIL b_sweep_done: got out=%h v/b/d=%b%b%b expected out=00 v/b/d=001",
               b_out, b_valid, b_busy, b_done);
    end
    step();
  endtask

  task automatic test_param_sel2_last0();
    c_en = 1'b1; c_sel = 2'd3;
    step();
    c_en = 1'b0;
    checks++;
    if ({c_out, c_valid} !== {4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL c_decode_sel3: got out=%b v=%b expected out=1000 v=1", c_out, c_valid);
    end
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    checks++;
    if ({c_out, c_valid, c_busy, c_done} !== {4'b0001, 3'b110}) begin
      errors++;
      $display("FAIL c_sweep_single: got out=%b v/b/d=%b%b%b expected out=0001 v/b/d=110",
               c_out, c_valid, c_busy, c_done);
    end
    step();
    checks++;
    if ({c_out, c_valid, c_busy, c_done} !== {4'b0000, 3'b001}) begin
      errors++;
      $display("FAIL c_sweep_done: got out=%b v/b/d=%b%b%b expected out=0000 v/b/d=001",
               c_out, c_valid, c_busy, c_done);
    end
    step();
  endtask

  task automatic test_random();
    int          m_state;  // 0 idle, 1 sweep, 2 done
    int          m_idx;
    logic [15:0] m_out;
    logic        m_busy, m_done;
    m_state = 0; m_idx = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      a_start = ($urandom_range(0, 29) == 0);
      a_en    = 1'($urandom_range(0, 1));
      a_sel   = 4'($urandom_range(0, 15));
      case (m_state)
        0: begin
          m_done = 1'b0;
          if (a_start) begin
            m_state = 1; m_idx = 0; m_out = 16'h0001; m_busy = 1'b1;
          end else if (a_en) begin
            m_out = 16'h0001 << a_sel; m_busy = 1'b0;
          end else begin
            m_out = 16'h0000; m_busy = 1'b0;
          end
        end
        1: begin
          if (m_idx == 15) begin
            m_state = 2; m_out = 16'h0000; m_busy = 1'b0; m_done = 1'b1;
          end else begin
            m_idx++; m_out = 16'h0001 << m_idx; m_busy = 1'b1; m_done = 1'b0;
          end
        end
        default: begin
          m_state = 0; m_out = 16'h0000; m_busy = 1'b0; m_done = 1'b0;
        end
      endcase
      step();
      checks++;
      if ({a_out, a_valid, a_busy, a_done} !== {m_out, |m_out, m_busy, m_done}) begin
        errors++;
        $display("FAIL rand_model cyc%0d: got out=%h v/b/d=%b%b%b expected out=%h v/b/d=%b%b%b",
                 cyc, a_out, a_valid, a_busy, a_done, m_out, |m_out, m_busy, m_done);
      end
      checks++;
      if (!($onehot0(a_out) && (a_valid == |a_out) && !(a_busy && a_done))) begin
        errors++;
        $display("FAIL rand_invariant cyc%0d: got out=%h v/b/d=%b%b%b expected onehot0, v==|out, !(busy&&done)",
                 cyc, a_out, a_valid, a_busy, a_done);
      end
    end
    a_start = 1'b0; a_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decode_all();
    test_sweep_full();
    test_priority();
    test_async_reset();
    test_param_sel3_last5();
    test_param_sel2_last0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
